// File: rtl/frame_scanout_pkg.sv
// rtl/frame_scanout_pkg.sv - shared types and geometry for frame scan-out
package frame_scanout_pkg;

  localparam int H_PIXELS_DEF = 320;
  localparam int V_LINES_DEF  = 240;
  localparam int ADDR_W_DEF   = 18;
  localparam int RGB565_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  // Counter width that stays legal for a count of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_scanout_if.sv
// rtl/frame_scanout_if.sv - frame memory read port and pixel stream
interface frame_scanout_if
  import frame_scanout_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = RGB565_W
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;

  modport master (
    output rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eol,
    input  rd_data, pix_ready
  );

  modport slave (
    input  rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eol,
    output rd_data, pix_ready
  );

endinterface

// File: rtl/scanout_fifo2.sv
// rtl/scanout_fifo2.sv - two-entry pixel FIFO with occupancy count
module scanout_fifo2
  import frame_scanout_pkg::*;
#(
  parameter int W = RGB565_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - per-tick scan-out of a double-buffered frame to the display stream
module frame_scanout
  import frame_scanout_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = RGB565_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic frame,
  input  logic wr_done,
  output logic back_bank,
  output logic busy,
  output logic overrun,
  frame_scanout_if.master io
);

  localparam int NPIX = H_PIXELS * V_LINES;
  localparam int IW   = cnt_w(NPIX);
  localparam int CW   = cnt_w(H_PIXELS);
  localparam int LW   = cnt_w(V_LINES);

  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(NPIX);
  localparam logic [IW-1:0]     LAST_IDX   = IW'(NPIX - 1);
  localparam logic [CW-1:0]     LAST_COL   = CW'(H_PIXELS - 1);
  localparam logic [LW-1:0]     LAST_LINE  = LW'(V_LINES - 1);

  scan_state_t       state, state_nxt;
  logic              front, pending, inflight;
  logic [IW-1:0]     rd_idx;
  logic [CW-1:0]     col;
  logic [LW-1:0]     line;
  logic              start, pop, last_pop;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic [1:0]        fifo_count;
  logic [2:0]        occ;
  logic [DATA_W-1:0] fifo_head;

  assign start     = (state == ST_IDLE) && frame;
  assign busy      = (state != ST_IDLE);
  assign overrun   = frame && busy;
  assign back_bank = ~front;

  // An empty FIFO lets the returning read bypass straight to the output.
  assign io.pix_valid = !fifo_empty || inflight;
  assign io.pix_data  = !fifo_empty ? fifo_head : (inflight ? io.rd_data : '0);
  assign io.pix_sof   = io.pix_valid && (col == '0) && (line == '0);
  assign io.pix_eol   = io.pix_valid && (col == LAST_COL);

  assign pop       = io.pix_valid && io.pix_ready;
  assign last_pop  = pop && (col == LAST_COL) && (line == LAST_LINE);
  assign fifo_pop  = pop && !fifo_empty;
  assign fifo_push = inflight && !(fifo_empty && pop);
  assign occ       = {1'b0, fifo_count} + {2'b00, inflight};

  always_comb begin
    state_nxt  = state;
    io.rd_en   = 1'b0;
    io.rd_addr = '0;
    case (state)
      ST_IDLE: if (frame) state_nxt = ST_SCAN;
      ST_SCAN: begin
        io.rd_en   = occ < (3'd2 + {2'b00, pop});
        io.rd_addr = (front ? BANK1_BASE : '0) + ADDR_W'(rd_idx);
        if (io.rd_en && (rd_idx == LAST_IDX)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (last_pop) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      inflight <= 1'b0;
      front    <= 1'b0;
      pending  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= io.rd_en;
      if (start && (pending || wr_done)) begin
        front   <= ~front;
        pending <= 1'b0;
      end else if (wr_done) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_idx <= '0;
      col    <= '0;
      line   <= '0;
    end else if (start) begin
      rd_idx <= '0;
      col    <= '0;
      line   <= '0;
    end else begin
      if (io.rd_en && (rd_idx != LAST_IDX)) rd_idx <= rd_idx + IW'(1);
      if (pop) begin
        if (col == LAST_COL) begin
          col  <= '0;
          line <= (line == LAST_LINE) ? '0 : line + LW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  scanout_fifo2 #(.W(DATA_W)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (io.rd_data),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule
